// File: rtl/jesd204b_rx_sync_ctrl.sv
// JESD204B receive link-layer sync controller: code group sync, ILAS tracking
// and DATA-state error monitoring, with a registered SYNC~ and transport enable.
module jesd204b_rx_sync_ctrl #(
  parameter int unsigned LANES        = 4,
  parameter int unsigned K_COUNT      = 4,
  parameter int unsigned ILAS_MF      = 4,
  parameter int unsigned ERR_THRESH   = 3,
  parameter int unsigned ILAS_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [LANES-1:0] lane_k_det,
  input  logic [LANES-1:0] lane_r_det,
  input  logic [LANES-1:0] lane_a_det,
  input  logic [LANES-1:0] lane_err,
  output logic             sync_n,
  output logic             tpl_en,
  output logic [1:0]       state,
  output logic [1:0]       err_cnt
);

  localparam int unsigned KW = $clog2(K_COUNT + 1);
  localparam int unsigned MW = $clog2(ILAS_MF + 1);
  localparam int unsigned TW = $clog2(ILAS_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CGS  = 2'd1,
    S_ILAS = 2'd2,
    S_DATA = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    kcnt_q [LANES];
  logic [KW-1:0]    kcnt_d [LANES];
  logic [LANES-1:0] started_q, started_d;
  logic [MW-1:0]    mf_q, mf_d;
  logic [TW-1:0]    ilas_cnt_q;
  logic             cgs_done, ilas_fail, ilas_done;
  logic             a_all, a_mis, data_err, err_hit;

  assign state = state_q;

  // Per-lane consecutive /K/ counters; a lane that misses /K/ or errors starts over.
  always_comb begin
    cgs_done = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      kcnt_d[i] = '0;
      if (lane_k_det[i] && !lane_err[i])
        kcnt_d[i] = (kcnt_q[i] == KW'(K_COUNT)) ? kcnt_q[i] : kcnt_q[i] + KW'(1);
      if (kcnt_d[i] != KW'(K_COUNT))
        cgs_done = 1'b0;
    end
  end

  // ILAS: a multiframe counts only when all lanes have started and /A/ lines up.
  always_comb begin
    started_d = started_q | lane_r_det;
    a_all     = &lane_a_det;
    a_mis     = (|lane_a_det) && !a_all;
    mf_d      = (a_all && (&started_q)) ? mf_q + MW'(1) : mf_q;
    ilas_fail = (|lane_err) || a_mis || (ilas_cnt_q == TW'(ILAS_TIMEOUT - 1));
    ilas_done = (mf_d == MW'(ILAS_MF));
    data_err  = |lane_err;
    err_hit   = data_err && ((32'(err_cnt) + 32'd1) >= ERR_THRESH);
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_CGS;
        S_CGS:  if (cgs_done) state_d = S_ILAS;
        S_ILAS: begin
          if (ilas_fail)      state_d = S_CGS;
          else if (ilas_done) state_d = S_DATA;
        end
        S_DATA: if (err_hit) state_d = S_CGS;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they move on the same edge as state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      sync_n     <= 1'b0;
      tpl_en     <= 1'b0;
      err_cnt    <= '0;
      started_q  <= '0;
      mf_q       <= '0;
      ilas_cnt_q <= '0;
      for (int i = 0; i < LANES; i++) kcnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sync_n  <= (state_d == S_ILAS) || (state_d == S_DATA);
      tpl_en  <= (state_d == S_DATA);
      for (int i = 0; i < LANES; i++)
        kcnt_q[i] <= (state_q == S_CGS && state_d == S_CGS) ? kcnt_d[i] : '0;
      if (state_q == S_ILAS && state_d == S_ILAS) begin
        started_q  <= started_d;
        mf_q       <= mf_d;
        ilas_cnt_q <= ilas_cnt_q + TW'(1);
      end else begin
        started_q  <= '0;
        mf_q       <= '0;
        ilas_cnt_q <= '0;
      end
      if (state_q != S_DATA && state_d == S_DATA)
        err_cnt <= '0;
      else if (state_q == S_DATA && data_err && err_cnt != 2'd3)
        err_cnt <= err_cnt + 2'd1;
    end
  end

endmodule

// File: tb/tb_jesd204b_rx_sync_ctrl.sv
// Directed bench for jesd204b_rx_sync_ctrl: bring-up, CGS break, misalignment,
// DATA errors, coincident disable, async reset and ILAS timeout.
module tb_jesd204b_rx_sync_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] lane_k_det = '0;
  logic [3:0] lane_r_det = '0;
  logic [3:0] lane_a_det = '0;
  logic [3:0] lane_err = '0;
  logic       sync_n;
  logic       tpl_en;
  logic [1:0] state;
  logic [1:0] err_cnt;

  int errors = 0;
  int checks = 0;

  jesd204b_rx_sync_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .lane_k_det (lane_k_det),
    .lane_r_det (lane_r_det),
    .lane_a_det (lane_a_det),
    .lane_err   (lane_err),
    .sync_n     (sync_n),
    .tpl_en     (tpl_en),
    .state      (state),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_st(input string tag, input logic [1:0] st, input logic sn, input logic te);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".sync_n"}, 32'(sync_n), 32'(sn));
    chk({tag, ".tpl_en"}, 32'(tpl_en), 32'(te));
  endtask

  initial begin
    // reset state
    cyc(2);
    chk_st("reset", 2'd0, 1'b0, 1'b0);
    chk("reset.err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // nominal bring-up
    enable = 1'b1;
    lane_k_det = 4'hF;
    cyc(1);
    chk_st("idle2cgs", 2'd1, 1'b0, 1'b0);
    cyc(3);
    chk_st("cgs_k3", 2'd1, 1'b0, 1'b0);
    cyc(1);
    chk_st("cgs_k4", 2'd2, 1'b1, 1'b0);
    lane_r_det = 4'hF;
    cyc(1);
    chk_st("ilas_r", 2'd2, 1'b1, 1'b0);
    lane_r_det = 4'h0;
    lane_a_det = 4'hF;
    cyc(3);
    chk_st("ilas_a3", 2'd2, 1'b1, 1'b0);
    cyc(1);
    chk_st("ilas_a4", 2'd3, 1'b1, 1'b1);
    chk("data_entry.err_cnt", 32'(err_cnt), 32'd0);
    lane_a_det = 4'h0;
    lane_k_det = 4'h0;

    // DATA errors on three separate cycles
    lane_err = 4'h1;
    cyc(1);
    chk("derr1.err_cnt", 32'(err_cnt), 32'd1);
    chk_st("derr1", 2'd3, 1'b1, 1'b1);
    lane_err = 4'h0;
    cyc(1);
    chk("dquiet1.err_cnt", 32'(err_cnt), 32'd1);
    lane_err = 4'h8;
    cyc(1);
    chk("derr2.err_cnt", 32'(err_cnt), 32'd2);
    chk_st("derr2", 2'd3, 1'b1, 1'b1);
    lane_err = 4'h0;
    cyc(1);
    lane_err = 4'h4;
    cyc(1);
    chk_st("derr3", 2'd1, 1'b0, 1'b0);
    lane_err = 4'h0;

    // CGS break on lane 2 at the third /K/ cycle
    lane_k_det = 4'hF;
    cyc(2);
    lane_k_det = 4'b1011;
    cyc(1);
    chk_st("cgs_break", 2'd1, 1'b0, 1'b0);
    lane_k_det = 4'hF;
    cyc(3);
    chk_st("cgs_lane2_k3", 2'd1, 1'b0, 1'b0);
    cyc(1);
    chk_st("cgs_lane2_k4", 2'd2, 1'b1, 1'b0);

    // ILAS misalignment
    lane_k_det = 4'h0;
    lane_r_det = 4'hF;
    cyc(1);
    lane_r_det = 4'h0;
    lane_a_det = 4'b0111;
    cyc(1);
    chk_st("ilas_misalign", 2'd1, 1'b0, 1'b0);
    lane_a_det = 4'h0;

    // disable coinciding with the final /A/
    lane_k_det = 4'hF;
    cyc(4);
    chk_st("reilas", 2'd2, 1'b1, 1'b0);
    lane_k_det = 4'h0;
    lane_r_det = 4'hF;
    cyc(1);
    lane_r_det = 4'h0;
    lane_a_det = 4'hF;
    cyc(3);
    enable = 1'b0;
    cyc(1);
    chk_st("disable_a4", 2'd0, 1'b0, 1'b0);
    lane_a_det = 4'h0;
    cyc(1);
    chk_st("disable_hold", 2'd0, 1'b0, 1'b0);

    // back to DATA, then async reset between edges
    enable = 1'b1;
    cyc(1);
    lane_k_det = 4'hF;
    cyc(4);
    lane_k_det = 4'h0;
    lane_r_det = 4'hF;
    cyc(1);
    lane_r_det = 4'h0;
    lane_a_det = 4'hF;
    cyc(4);
    chk_st("data_again", 2'd3, 1'b1, 1'b1);
    lane_a_det = 4'h0;
    #2;
    reset = 1'b0;
    #1;
    chk_st("async_reset", 2'd0, 1'b0, 1'b0);
    chk("async_reset.err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc(1);
    chk_st("post_reset", 2'd1, 1'b0, 1'b0);

    // ILAS timeout with no /R/ or /A/ ever arriving
    lane_k_det = 4'hF;
    cyc(4);
    lane_k_det = 4'h0;
    chk_st("to_entry", 2'd2, 1'b1, 1'b0);
    cyc(1023);
    chk_st("to_last", 2'd2, 1'b1, 1'b0);
    cyc(1);
    chk_st("to_fire", 2'd1, 1'b0, 1'b0);

    // lane error during ILAS
    lane_k_det = 4'hF;
    cyc(4);
    lane_k_det = 4'h0;
    lane_err = 4'h2;
    cyc(1);
    chk_st("ilas_err", 2'd1, 1'b0, 1'b0);
    lane_err = 4'h0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
